// File: rtl/text_stream_pkg.sv
// Shared types and constants for the text streaming source and downstream framing.
package text_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int FIFO_DEPTH  = 2;
  localparam int TEXT_DATA_W = 8;
  localparam int TEXT_ADDR_W = 8;

endpackage

// File: rtl/text_ram.sv
// Single-port synchronous-read text memory, preloaded with an address ramp (mem[a] = a).
module text_ram #(
   parameter int    DATA_W    = 8,
   parameter int    ADDR_W    = 8,
   parameter string INIT_FILE = ""
) (
   input  logic [ADDR_W-1:0] address,
   input  logic              clock,
   input  logic [DATA_W-1:0] data,
   input  logic              wren,
   output logic [DATA_W-1:0] q
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   initial begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'(i);
   end

   always @(posedge clock) begin
      if (wren) mem[address] <= data;
      q <= mem[address];
   end

endmodule

// File: rtl/text_stream_source.sv
// Streams the START_ADDR..END_ADDR window of the text memory onto a
// valid/ready byte stream, with abort, end-of-message flag and optional looping.
//
// state   | meaning
// IDLE    | waiting for start_source, stream empty
// RUN     | issuing reads and draining the output FIFO
// DONE    | single pass finished (LOOP=0), waiting for restart
module text_stream_source
  import text_stream_pkg::*;
#(
  parameter int    DATA_W     = TEXT_DATA_W,
  parameter int    ADDR_W     = TEXT_ADDR_W,
  parameter int    START_ADDR = 0,
  parameter int    END_ADDR   = 255,
  parameter int    LOOP       = 0,
  parameter string INIT_FILE  = "text.mif"
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_source,
  input  logic              abort,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              data_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
  localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
  localparam bit                LOOP_EN = (LOOP != 0);

  state_e            state;
  logic [ADDR_W-1:0] rd_addr;
  logic              issued_all;
  logic              in_flight;
  logic              in_flight_last;
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        fifo_count;
  logic [2:0]        occupancy;
  logic [DATA_W-1:0] ram_q;
  logic              pop;
  logic              push;
  logic              issue;
  logic              at_end;

  text_ram #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .INIT_FILE(INIT_FILE)
  ) u_text_ram (
    .address(rd_addr),
    .clock  (clk),
    .data   ('0),
    .wren   (1'b0),
    .q      (ram_q)
  );

  assign data_valid = (fifo_count != 2'd0);
  assign data_out   = fifo_data[rd_ptr];
  assign data_last  = fifo_last[rd_ptr];
  assign busy       = (state == ST_RUN);
  assign done       = (state == ST_DONE);

  assign pop    = data_valid && data_ready;
  assign push   = in_flight;
  assign at_end = (rd_addr == END_A);

  // Occupancy net of the word leaving this cycle keeps the pipe bubble-free.
  assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};
  assign issue     = (state == ST_RUN) && !abort && !issued_all && (occupancy < 3'd2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      rd_addr        <= START_A;
      issued_all     <= 1'b0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      fifo_last      <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      fifo_count     <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data[i] <= '0;
    end else if (abort) begin
      state          <= ST_IDLE;
      issued_all     <= 1'b0;
      in_flight      <= 1'b0;
      in_flight_last <= 1'b0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      fifo_count     <= 2'd0;
    end else begin
      in_flight <= issue;
      if (issue) begin
        in_flight_last <= at_end;
        rd_addr        <= at_end ? START_A : rd_addr + 1'b1;
        if (at_end && !LOOP_EN) issued_all <= 1'b1;
      end
      if (push) begin
        fifo_data[wr_ptr] <= ram_q;
        fifo_last[wr_ptr] <= in_flight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_source) begin
            state      <= ST_RUN;
            rd_addr    <= START_A;
            issued_all <= 1'b0;
          end
        end
        ST_RUN: begin
          if (pop && data_last && !LOOP_EN) state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_stream_source.sv
// Randomised bench for text_stream_source: three instances (single pass, looping,
// one-word window at the top address) checked against a message-level model.
module tb_text_stream_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       ready;
  logic [7:0] dout [3];
  logic       vld  [3];
  logic       lst  [3];
  logic       bsy  [3];
  logic       dn   [3];

  int p_s [3] = '{4, 4, 255};
  int p_e [3] = '{7, 7, 255};
  int p_l [3] = '{0, 1, 0};

  // model: 0 idle, 1 run, 2 done; m_next is the next word owed downstream
  int m_st   [3];
  int m_next [3];
  int m_age  [3];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  text_stream_source #(.DATA_W(8), .ADDR_W(8), .START_ADDR(4), .END_ADDR(7),
                       .LOOP(0), .INIT_FILE("")) u_single (
    .clk(clk), .reset(rst_n), .start_source(start), .abort(abort), .data_ready(ready),
    .data_out(dout[0]), .data_valid(vld[0]), .data_last(lst[0]), .busy(bsy[0]), .done(dn[0]));

  text_stream_source #(.DATA_W(8), .ADDR_W(8), .START_ADDR(4), .END_ADDR(7),
                       .LOOP(1), .INIT_FILE("")) u_loop (
    .clk(clk), .reset(rst_n), .start_source(start), .abort(abort), .data_ready(ready),
    .data_out(dout[1]), .data_valid(vld[1]), .data_last(lst[1]), .busy(bsy[1]), .done(dn[1]));

  text_stream_source #(.DATA_W(8), .ADDR_W(8), .START_ADDR(255), .END_ADDR(255),
                       .LOOP(0), .INIT_FILE("")) u_top (
    .clk(clk), .reset(rst_n), .start_source(start), .abort(abort), .data_ready(ready),
    .data_out(dout[2]), .data_valid(vld[2]), .data_last(lst[2]), .busy(bsy[2]), .done(dn[2]));

  // Message-level reference: a word is owed from two edges after start until END is taken.
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || abort) begin
        m_st[i] = 0;
      end else if (m_st[i] != 1) begin
        if (start) begin
          m_st[i]   = 1;
          m_next[i] = p_s[i];
          m_age[i]  = 0;
        end
      end else begin
        if (m_age[i] >= 2 && ready) begin
          if (m_next[i] == p_e[i]) begin
            if (p_l[i] != 0) m_next[i] = p_s[i];
            else m_st[i] = 2;
          end else begin
            m_next[i] = m_next[i] + 1;
          end
        end
        if (m_age[i] < 2) m_age[i] = m_age[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    bit exp_v;
    for (int i = 0; i < 3; i++) begin
      exp_v = (m_st[i] == 1) && (m_age[i] >= 2);
      chk($sformatf("valid[%0d]", i), int'(vld[i]), int'(exp_v));
      if (exp_v) begin
        chk($sformatf("data[%0d]", i), int'(dout[i]), m_next[i] & 255);
        chk($sformatf("last[%0d]", i), int'(lst[i]), int'(m_next[i] == p_e[i]));
      end
      chk($sformatf("busy[%0d]", i), int'(bsy[i]), int'(m_st[i] == 1));
      chk($sformatf("done[%0d]", i), int'(dn[i]), int'(m_st[i] == 2));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_data[%0d]", tag, i), int'(dout[i]), 0);
      chk($sformatf("%s_valid[%0d]", tag, i), int'(vld[i]), 0);
      chk($sformatf("%s_last[%0d]", tag, i), int'(lst[i]), 0);
      chk($sformatf("%s_busy[%0d]", tag, i), int'(bsy[i]), 0);
      chk($sformatf("%s_done[%0d]", tag, i), int'(dn[i]), 0);
    end
  endtask

  task automatic step(input bit s, input bit a, input bit r);
    start = s;
    abort = a;
    ready = r;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int xfers;
    int nlast;
    bit [5:0] toggle_pat;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    step(0, 0, 1);

    // single pass with ready high: 4,5,6,7 back to back, then DONE
    step(1, 0, 1);
    repeat (8) step(0, 0, 1);

    // ready pattern 1,0,0,1,0,1 repeating
    toggle_pat = 6'b101001;
    step(0, 1, 1);
    step(1, 0, 1);
    for (int c = 0; c < 24; c++) step(0, 0, toggle_pat[c % 6]);

    // looping instance: 12 transfers carry exactly three last flags
    step(0, 1, 1);
    step(1, 0, 1);
    xfers = 0;
    nlast = 0;
    for (int c = 0; c < 40 && xfers < 12; c++) begin
      if (vld[1]) begin
        xfers++;
        if (lst[1]) nlast++;
      end
      step(0, 0, 1);
    end
    chk("loop_xfers", xfers, 12);
    chk("loop_lasts", nlast, 3);

    // abort together with start right after word 5 is taken, then replay
    step(0, 1, 1);
    step(1, 0, 1);
    repeat (4) step(0, 0, 1);
    step(1, 1, 1);
    chk("abort_valid", int'(vld[0]), 0);
    step(1, 0, 1);
    repeat (8) step(0, 0, 1);

    // asynchronous reset mid-stream, then restart
    step(0, 1, 1);
    step(1, 0, 1);
    repeat (3) step(0, 0, ($urandom % 2) != 0);
    #3 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1);
    step(1, 0, 1);
    repeat (8) step(0, 0, 1);

    // random control and backpressure
    for (int c = 0; c < 2000; c++) begin
      step(($urandom % 6) == 0, ($urandom % 29) == 0, ($urandom % 4) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
